// File: rtl/rr_channel_mux.sv
// N-channel registered mux with valid/ready on every input and on the output.
// Fixed-select or round-robin arbitration; counts completed output handshakes.
module rr_channel_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               xfer_count
);

  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic                r_valid;
  logic [SEL_W-1:0]    r_ptr;
  logic [15:0]         r_cnt;

  logic                w_load_en;
  logic                w_gnt_vld;
  logic [SEL_W-1:0]    w_gnt;
  logic [SEL_W:0]      w_sum;
  logic [CHANNELS-1:0] w_rdy;
  logic                w_xfer_in;
  logic                w_xfer_out;
  logic [SEL_W-1:0]    w_ptr_nxt;

  assign w_load_en  = !r_valid || out_ready;
  assign w_xfer_out = r_valid && out_ready;

  // Round-robin scan walks offsets from ptr, wrapping at CHANNELS (not 2^SEL_W).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_sum     = '0;
    if (mode) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        w_sum = {1'b0, r_ptr} + (SEL_W+1)'(k);
        if (w_sum >= (SEL_W+1)'(CHANNELS))
          w_sum = w_sum - (SEL_W+1)'(CHANNELS);
        if (!w_gnt_vld && in_valid[w_sum[SEL_W-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = w_sum[SEL_W-1:0];
        end
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_rdy = '0;
    if (!reset && w_load_en && w_gnt_vld)
      w_rdy[w_gnt] = 1'b1;
  end

  assign w_xfer_in = |w_rdy;
  assign w_ptr_nxt = (w_gnt == SEL_W'(CHANNELS-1)) ? '0 : w_gnt + SEL_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer_in) begin
        r_data  <= in_data[w_gnt*WIDTH +: WIDTH];
        r_chan  <= w_gnt;
        r_valid <= 1'b1;
        if (mode)
          r_ptr <= w_ptr_nxt;
      end else if (w_xfer_out) begin
        r_valid <= 1'b0;
      end
      if (w_xfer_out)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign in_ready   = w_rdy;
  assign out_data   = r_data;
  assign out_chan   = r_chan;
  assign out_valid  = r_valid;
  assign xfer_count = r_cnt;

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed bench for rr_channel_mux: vector table plus reset, wrap and
// out-of-range select sequences on a 4-channel and a 3-channel instance.
module tb_rr_channel_mux;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        mode, ordy;
  logic [1:0]  sel;
  logic [3:0]  vld;
  logic [31:0] dw [4];
  logic [127:0] din;
  logic [3:0]  rdy;
  logic [31:0] odata;
  logic [1:0]  ochan;
  logic        ovalid;
  logic [15:0] cnt;

  assign din = {dw[3], dw[2], dw[1], dw[0]};

  rr_channel_mux #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(din), .in_valid(vld), .in_ready(rdy),
    .out_data(odata), .out_chan(ochan), .out_valid(ovalid),
    .out_ready(ordy), .xfer_count(cnt));

  // 3-channel instance
  logic        m3, ordy3;
  logic [1:0]  sel3;
  logic [2:0]  vld3, rdy3;
  logic [95:0] din3;
  logic [31:0] odata3;
  logic [1:0]  ochan3;
  logic        ovalid3;
  logic [15:0] cnt3;

  assign din3 = {32'hB2, 32'hB1, 32'hB0};

  rr_channel_mux #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .mode(m3), .sel(sel3),
    .in_data(din3), .in_valid(vld3), .in_ready(rdy3),
    .out_data(odata3), .out_chan(ochan3), .out_valid(ovalid3),
    .out_ready(ordy3), .xfer_count(cnt3));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [1:0]  e_ch;
    logic [31:0] e_d;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // fixed sel=2, all valid
    tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 16'd0};
    tbl[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 16'd1};
    tbl[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 16'd2};
    // round-robin, all valid: ptr untouched by fixed mode, starts at 0
    tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 16'd3};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1, 16'd4};
    tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 16'd5};
    tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 16'd6};
    tbl[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 16'd7};
    // sparse 1010
    tbl[8]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1, 16'd8};
    tbl[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 16'd9};
    tbl[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1, 16'd10};
    tbl[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 16'd11};
    // backpressure x3, then release
    tbl[12] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3, 16'd11};
    tbl[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3, 16'd11};
    tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3, 16'd11};
    tbl[15] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 16'd12};
    // drain, idle, then channel 1 absent: ptr=1 skips to 2
    tbl[16] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0, 16'd13};
    tbl[17] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0, 16'd13};
    tbl[18] = '{1'b1, 2'd0, 4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 16'd13};
    // fixed sel=1 not valid: others ignored
    tbl[19] = '{1'b0, 2'd1, 4'hD, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2, 16'd14};
    // empty register loads even with out_ready low, then holds
    tbl[20] = '{1'b0, 2'd0, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA0, 16'd14};
    tbl[21] = '{1'b0, 2'd0, 4'h1, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0, 16'd14};
    tbl[22] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0, 16'd15};

    for (int i = 0; i < 4; i++) dw[i] = 32'hA0 + 32'(i);
    reset = 1'b1; mode = 1'b0; sel = '0; vld = '0; ordy = 1'b0;
    m3 = 1'b0; sel3 = '0; vld3 = '0; ordy3 = 1'b0;
    #12;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_odata", odata, 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    vld = 4'hF;
    #1 chk("rst_inready", 32'(rdy), 32'd0);
    vld = '0;
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      mode = tbl[i].mode; sel = tbl[i].sel; vld = tbl[i].vld; ordy = tbl[i].ordy;
      #1 chk($sformatf("v%0d_inready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ovalid", i), 32'(ovalid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_ochan", i), 32'(ochan), 32'(tbl[i].e_ch));
      chk($sformatf("v%0d_odata", i), odata, tbl[i].e_d);
      chk($sformatf("v%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
    end

    // reset while holding 0x55 (ptr is 3 beforehand)
    @(negedge clk);
    dw[1] = 32'h55; mode = 1'b0; sel = 2'd1; vld = 4'b0010; ordy = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_data", odata, 32'h55);
    chk("pre_rst_valid", 32'(ovalid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ovalid", 32'(ovalid), 32'd0);
    chk("midrst_odata", odata, 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_inready", 32'(rdy), 32'd0);
    @(negedge clk);
    reset = 1'b0; dw[1] = 32'hA1; mode = 1'b1; vld = 4'hF; ordy = 1'b1;
    #1 chk("midrst_ptr0", 32'(rdy), 32'b0001);
    @(posedge clk); #1;
    chk("midrst_first_chan", 32'(ochan), 32'd0);
    chk("midrst_cnt_after", 32'(cnt), 32'd0);

    // counter wrap: N edges from empty give N-1 handshakes
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (65536) @(posedge clk);
    #1 chk("cnt_ffff", 32'(cnt), 32'hFFFF);
    @(posedge clk);
    #1 chk("cnt_wrap", 32'(cnt), 32'h0000);
    chk("wrap_ovalid", 32'(ovalid), 32'd1);

    // 3-channel instance: sel=3 is out of range
    @(negedge clk);
    ordy = 1'b0; vld = '0;
    m3 = 1'b0; sel3 = 2'd3; vld3 = 3'b111; ordy3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("c3_sel3_inready%0d", i), 32'(rdy3), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("c3_sel3_ovalid%0d", i), 32'(ovalid3), 32'd0);
      @(negedge clk);
    end
    sel3 = 2'd2;
    #1 chk("c3_sel2_inready", 32'(rdy3), 32'b100);
    @(posedge clk); #1;
    chk("c3_sel2_data", odata3, 32'hB2);
    chk("c3_sel2_chan", 32'(ochan3), 32'd2);
    // round-robin wrap at CHANNELS-1: 2 -> 0 (ptr starts 0, grants 0,1,2,0)
    @(negedge clk);
    m3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("c3_rr%0d", i), 32'(ochan3), 32'(i % 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
